mycpu_wb: RTL and testbench

MYCPU_WB -- requirements
Module: mycpu_wb

---
 rtl/mycpu_pkg.sv | 28 ++
 rtl/mycpu_ld_align.sv | 32 +++
 rtl/mycpu_wb.sv | 108 ++++++++++
 tb/tb_mycpu_wb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: datapath widths, load-op encodings and writeback state encoding.
package mycpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_B    = 3'd1,
        LD_BU   = 3'd2,
        LD_H    = 3'd3,
        LD_HU   = 3'd4,
        LD_W    = 3'd5
    } ld_op_e;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_ALU  = 2'd1,
        WS_WAIT = 2'd2,
        WS_HAVE = 2'd3
    } ws_state_e;

    // Encodings 6 and 7 are reserved and behave as "no load".
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_B) && (op <= LD_W);
    endfunction

endpackage

// File: rtl/mycpu_ld_align.sv
// Combinational load extraction: selects byte/half/word by address and sign/zero extends.
module mycpu_ld_align
    import mycpu_pkg::*;
(
    input  logic [2:0]        ld_op,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        case (ld_op)
            LD_B:    wdata = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   wdata = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_H:    wdata = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_HU:   wdata = {{(DATA_W-16){1'b0}}, half_sel};
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/mycpu_wb.sv
// Writeback stage: one-entry holding register, load data wait/latch, register-file write and forwarding.
// Optional trace ports are enabled with MYCPU_WB_TRACE_EN.
module mycpu_wb
    import mycpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ms_valid,
    output logic              ws_allowin,
    input  logic [31:0]       ms_pc,
    input  logic [REG_W-1:0]  ms_dest,
    input  logic [DATA_W-1:0] ms_res,
    input  logic [2:0]        ms_ld_op,
    input  logic              dm_rvalid,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_pending
`ifdef MYCPU_WB_TRACE_EN
    ,
    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_wen,
    output logic [REG_W-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0] debug_wb_rf_wdata
`endif
);

    ws_state_e         state;
    ws_state_e         state_nxt;
    logic              ws_valid;
    logic              ws_ready_go;
    logic              capture;
    logic              commit;
    logic              ld_latch;
    logic [31:0]       pc_p0;
    logic [REG_W-1:0]  dest_p0;
    logic [DATA_W-1:0] res_p0;
    logic [2:0]        ld_op_p0;
    logic [DATA_W-1:0] ld_data_p0;
    logic [DATA_W-1:0] ld_src;
    logic [DATA_W-1:0] ld_wdata;
    logic [DATA_W-1:0] wb_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WS_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (capture)       state_nxt = is_load(ms_ld_op) ? WS_WAIT : WS_ALU;
        else if (commit)   state_nxt = WS_IDLE;
        else if (ld_latch) state_nxt = WS_HAVE;
    end

    // Nothing downstream stalls commit today; HAVE covers data arriving while commit is held off.
    always_comb begin
        ws_valid    = (state != WS_IDLE);
        ws_ready_go = (state != WS_WAIT) || dm_rvalid;
        ws_allowin  = !ws_valid || ws_ready_go;
        capture     = ms_valid && ws_allowin;
        commit      = ws_valid && ws_ready_go;
        ld_latch    = (state == WS_WAIT) && dm_rvalid && !commit;
        fwd_pending = (state == WS_WAIT) && !dm_rvalid;
        rf_wen      = commit && (dest_p0 != '0);
        fwd_valid   = ws_valid && (dest_p0 != '0);
        rf_waddr    = ws_valid ? dest_p0 : '0;
        fwd_dest    = ws_valid ? dest_p0 : '0;
        rf_wdata    = ws_valid ? wb_data : '0;
        fwd_data    = ws_valid ? wb_data : '0;
    end

    // Stage p0: captured instruction and latched load data (no reset; qualified by state).
    always_ff @(posedge clk) begin
        if (capture) begin
            pc_p0    <= ms_pc;
            dest_p0  <= ms_dest;
            res_p0   <= ms_res;
            ld_op_p0 <= ms_ld_op;
        end
        if (ld_latch) ld_data_p0 <= dm_rdata;
    end

    assign ld_src  = (state == WS_HAVE) ? ld_data_p0 : dm_rdata;
    assign wb_data = (state == WS_ALU) ? res_p0 : ld_wdata;

    mycpu_ld_align u_ld_align (
        .ld_op (ld_op_p0),
        .addr  (res_p0[1:0]),
        .rdata (ld_src),
        .wdata (ld_wdata)
    );

`ifdef MYCPU_WB_TRACE_EN
    assign debug_wb_pc       = ws_valid ? pc_p0 : '0;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    logic unused_pc;
    assign unused_pc = ^pc_p0;
`endif

endmodule

// File: tb/tb_mycpu_wb.sv
// Self-checking bench for mycpu_wb: directed scenarios followed by randomized traffic against a reference model.
module tb_mycpu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic [31:0] ms_res;
    logic [2:0]  ms_ld_op;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_pending;

    always #5 clk = ~clk;

    mycpu_wb dut (
        .clk         (clk),
        .rst         (rst),
        .ms_valid    (ms_valid),
        .ws_allowin  (ws_allowin),
        .ms_pc       (ms_pc),
        .ms_dest     (ms_dest),
        .ms_res      (ms_res),
        .ms_ld_op    (ms_ld_op),
        .dm_rvalid   (dm_rvalid),
        .dm_rdata    (dm_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fwd_valid   (fwd_valid),
        .fwd_dest    (fwd_dest),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the instruction currently held, if any.
    logic        m_valid = 1'b0;
    logic [4:0]  m_dest;
    logic [31:0] m_res;
    logic [2:0]  m_op;
    logic        e_allowin;
    logic        e_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_is_load(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (rd >> (16 * addr[1])) & 32'h0000_FFFF;
        case (op)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    task automatic compare_model();
        logic        ld;
        logic        e_wen;
        logic        e_fwd;
        logic [31:0] e_data;
        ld        = m_valid && ref_is_load(m_op);
        e_pend    = ld && !dm_rvalid;
        e_allowin = !e_pend;
        e_wen     = m_valid && !e_pend && (m_dest != 5'd0);
        e_fwd     = m_valid && (m_dest != 5'd0);
        e_data    = ld ? ref_load(m_op, m_res, dm_rdata) : m_res;
        chk("allowin", 32'(ws_allowin), 32'(e_allowin));
        chk("rf_wen", 32'(rf_wen), 32'(e_wen));
        chk("fwd_pending", 32'(fwd_pending), 32'(e_pend));
        chk("fwd_valid", 32'(fwd_valid), 32'(e_fwd));
        if (e_wen) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_dest));
            chk("rf_wdata", rf_wdata, e_data);
        end
        if (e_fwd) chk("fwd_dest", 32'(fwd_dest), 32'(m_dest));
        if (e_fwd && !e_pend) chk("fwd_data", fwd_data, e_data);
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] r,
                         input logic [2:0] op, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        ms_valid  = v;
        ms_pc     = $urandom;
        ms_dest   = d;
        ms_res    = r;
        ms_ld_op  = op;
        dm_rvalid = rv;
        dm_rdata  = rd;
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        if (ms_valid && e_allowin) begin
            m_valid = 1'b1;
            m_dest  = ms_dest;
            m_res   = ms_res;
            m_op    = ms_ld_op;
        end else if (m_valid && !e_pend) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_allowin"}, 32'(ws_allowin), 32'd1);
        chk({tag, "_wen"}, 32'(rf_wen), 32'd0);
        chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({tag, "_pending"}, 32'(fwd_pending), 32'd0);
        chk({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
        chk({tag, "_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_fwd_dest"}, 32'(fwd_dest), 32'd0);
        chk({tag, "_fwd_data"}, fwd_data, 32'd0);
    endtask

    initial begin
        rst = 1'b0; ms_valid = 1'b0; ms_pc = '0; ms_dest = '0; ms_res = '0;
        ms_ld_op = '0; dm_rvalid = 1'b0; dm_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;

        // ADD to r5 writes once, one cycle after capture.
        drive(1, 5'd5, 32'h1234_5678, 3'd0, 0, 32'h0); tick();
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("add_wen", 32'(rf_wen), 32'd1);
        chk("add_waddr", 32'(rf_waddr), 32'd5);
        chk("add_wdata", rf_wdata, 32'h1234_5678);
        tick();
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("add_once", 32'(rf_wen), 32'd0);
        tick();

        // Destination r0 never writes or forwards.
        drive(1, 5'd0, 32'hFFFF_FFFF, 3'd0, 0, 32'h0); tick();
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("r0_wen", 32'(rf_wen), 32'd0);
        chk("r0_fwd", 32'(fwd_valid), 32'd0);
        tick();

        // LB / LBU at byte 3 with data in the first cycle.
        drive(1, 5'd3, 32'h1000_0003, 3'd1, 0, 32'h0); tick();
        drive(0, 5'd0, 32'h0, 3'd0, 1, 32'h80FF_0000);
        chk("lb_wen", 32'(rf_wen), 32'd1);
        chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        tick();
        drive(1, 5'd4, 32'h1000_0003, 3'd2, 0, 32'h0); tick();
        drive(0, 5'd0, 32'h0, 3'd0, 1, 32'h80FF_0000);
        chk("lbu_wdata", rf_wdata, 32'h0000_0080);
        tick();

        // LH at half 1, data three cycles late; a waiting ADD is captured on the commit edge.
        drive(1, 5'd7, 32'h0000_1002, 3'd3, 0, 32'h0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'd12, 32'hCAFE_0000, 3'd0, 0, $urandom);
            chk("lh_pend", 32'(fwd_pending), 32'd1);
            chk("lh_allowin", 32'(ws_allowin), 32'd0);
            chk("lh_wen_wait", 32'(rf_wen), 32'd0);
            tick();
        end
        drive(1, 5'd12, 32'hCAFE_0000, 3'd0, 1, 32'h8001_1234);
        chk("lh_wen", 32'(rf_wen), 32'd1);
        chk("lh_waddr", 32'(rf_waddr), 32'd7);
        chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
        chk("lh_allowin_go", 32'(ws_allowin), 32'd1);
        tick();
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("share_wen", 32'(rf_wen), 32'd1);
        chk("share_waddr", 32'(rf_waddr), 32'd12);
        chk("share_wdata", rf_wdata, 32'hCAFE_0000);
        tick();

        // Back-to-back non-loads write on consecutive cycles.
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(i + 1), 32'h100 + 32'(i), 3'd0, 0, 32'h0);
            chk("b2b_allowin", 32'(ws_allowin), 32'd1);
            if (i > 0) begin
                chk("b2b_wen", 32'(rf_wen), 32'd1);
                chk("b2b_waddr", 32'(rf_waddr), 32'(i));
            end
            tick();
        end
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("b2b_last", 32'(rf_waddr), 32'd5);
        tick();

        // Reset while a LW waits: discarded even with data arriving.
        drive(1, 5'd9, 32'h0000_0004, 3'd5, 0, 32'h0); tick();
        drive(0, 5'd0, 32'h0, 3'd0, 0, 32'h0);
        chk("rl_pend", 32'(fwd_pending), 32'd1);
        #1;
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h5555_AAAA;
        rst       = 1'b0;
        #1 chk_reset_outputs("rl");
        m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rl_after_allowin", 32'(ws_allowin), 32'd1);
        chk("rl_after_wen", 32'(rf_wen), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom,
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 4),
                  $urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
